// File: rtl/name_match_monitor_if.sv
// Bundles the detector-side input and statistics outputs of name_match_monitor.
// The master drives clr/eureka and observes the results; the slave is the monitor itself.
interface name_match_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             clr;
   logic [7:0]       eureka;
   logic [3:0]       progress;
   logic             match_pulse;
   logic [CNT_W-1:0] match_count;
   logic [CNT_W-1:0] near_miss_count;
   logic [3:0]       best_progress;
   logic             led;
   logic             code_err;

   modport master (
      output clr, eureka,
      input  progress, match_pulse, match_count, near_miss_count, best_progress, led, code_err
   );

   modport slave (
      input  clr, eureka,
      output progress, match_pulse, match_count, near_miss_count, best_progress, led, code_err
   );
endinterface

// File: rtl/name_match_monitor.sv
// Decodes the RITUSHREE detector's eureka progress code and keeps match/near-miss
// statistics, best progress, a sticky illegal-code flag and a stretched LED.
module name_match_monitor #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned STRETCH  = 16,
   parameter int unsigned NEAR_MIN = 5
) (
   input logic                clk,
   input logic                rst,
   name_match_monitor_if.slave bus
);
   localparam int unsigned SW = $clog2(STRETCH + 1);
   localparam logic [3:0]  NearMin = 4'(NEAR_MIN);
   localparam logic [SW-1:0] StretchLoad = SW'(STRETCH);

   logic [3:0]       cur;
   logic             illegal;
   logic             match;
   logic             near_miss;

   logic [3:0]       progress_q, progress_d;
   logic             match_pulse_q, match_pulse_d;
   logic [CNT_W-1:0] match_count_q, match_count_d;
   logic [CNT_W-1:0] near_miss_q, near_miss_d;
   logic [3:0]       best_q, best_d;
   logic             code_err_q, code_err_d;
   logic [SW-1:0]    stretch_q, stretch_d;

   always_comb begin
      cur     = 4'd0;
      illegal = 1'b0;
      case (bus.eureka)
         8'h00:   cur = 4'd0;
         8'h80:   cur = 4'd1;
         8'hC0:   cur = 4'd2;
         8'hE0:   cur = 4'd3;
         8'hF0:   cur = 4'd4;
         8'hF8:   cur = 4'd5;
         8'hFC:   cur = 4'd6;
         8'hFE:   cur = 4'd7;
         8'hFF:   cur = 4'd8;
         8'h01:   cur = 4'd9;
         default: illegal = 1'b1;
      endcase
   end

   // The progress register doubles as the previous sample for the event tests.
   assign match     = (cur == 4'd9) && (progress_q != 4'd9);
   assign near_miss = (progress_q >= NearMin) && (progress_q <= 4'd8) && (cur < progress_q);

   always_comb begin
      progress_d    = cur;
      match_pulse_d = match;
      match_count_d = match_count_q;
      near_miss_d   = near_miss_q;
      best_d        = (cur > best_q) ? cur : best_q;
      code_err_d    = code_err_q | illegal;
      stretch_d     = stretch_q;

      if (match && (match_count_q != '1)) match_count_d = match_count_q + 1'b1;
      if (near_miss && (near_miss_q != '1)) near_miss_d = near_miss_q + 1'b1;

      if (match) begin
         stretch_d = StretchLoad;
      end else if (stretch_q != '0) begin
         stretch_d = stretch_q - 1'b1;
      end

      // clr discards any same-cycle event; progress keeps tracking eureka.
      if (bus.clr) begin
         match_pulse_d = 1'b0;
         match_count_d = '0;
         near_miss_d   = '0;
         best_d        = 4'd0;
         code_err_d    = 1'b0;
         stretch_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         progress_q    <= 4'd0;
         match_pulse_q <= 1'b0;
         match_count_q <= '0;
         near_miss_q   <= '0;
         best_q        <= 4'd0;
         code_err_q    <= 1'b0;
         stretch_q     <= '0;
      end else begin
         progress_q    <= progress_d;
         match_pulse_q <= match_pulse_d;
         match_count_q <= match_count_d;
         near_miss_q   <= near_miss_d;
         best_q        <= best_d;
         code_err_q    <= code_err_d;
         stretch_q     <= stretch_d;
      end
   end

   assign bus.progress        = progress_q;
   assign bus.match_pulse     = match_pulse_q;
   assign bus.match_count     = match_count_q;
   assign bus.near_miss_count = near_miss_q;
   assign bus.best_progress   = best_q;
   assign bus.code_err        = code_err_q;
   assign bus.led             = (stretch_q != '0);
endmodule

// File: tb/tb_name_match_monitor.sv
// Scoreboard bench: a letter-count reference model predicts each cycle's outputs for an
// 8-bit-counter and a 2-bit-counter instance; a monitor pops and compares after each edge.
module tb_name_match_monitor;
   localparam int STRETCH = 16;
   localparam int NEAR_MIN = 5;

   typedef struct {
      int progress;
      int pulse;
      int mc8;
      int nm8;
      int mc2;
      int nm2;
      int best;
      int led;
      int err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   name_match_monitor_if #(.CNT_W(8)) bus8 ();
   name_match_monitor_if #(.CNT_W(2)) bus2 ();
   assign bus2.clr    = bus8.clr;
   assign bus2.eureka = bus8.eureka;

   name_match_monitor #(.CNT_W(8), .STRETCH(STRETCH), .NEAR_MIN(NEAR_MIN)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );
   name_match_monitor #(.CNT_W(2), .STRETCH(STRETCH), .NEAR_MIN(NEAR_MIN)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   logic [7:0] codes [10] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0,
                              8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h01};

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: plain letter counts and unbounded event totals.
   int m_prev = 0, m_matches = 0, m_near = 0, m_best = 0, m_err = 0, m_left = 0, m_pulse = 0;

   function automatic int letters_of(input logic [7:0] e);
      for (int i = 0; i < 10; i++) if (codes[i] == e) return i;
      return -1;
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
   endtask

   task automatic step(input logic r, input logic c, input logic [7:0] e);
      int   cur;
      exp_t x;
      logic rose;
      @(negedge clk);
      rose = r && !rst;
      rst = r;
      bus8.clr = c;
      bus8.eureka = e;
      if (rose) begin
         #1;
         check("rst_async_progress", int'(bus8.progress), 0);
         check("rst_async_led", int'(bus8.led), 0);
         check("rst_async_count", int'(bus8.match_count) + int'(bus8.near_miss_count), 0);
      end
      cur = letters_of(e);
      if (r) begin
         m_prev = 0; m_matches = 0; m_near = 0; m_best = 0; m_err = 0; m_left = 0; m_pulse = 0;
         cur = 0;
      end else begin
         if (cur < 0) begin
            cur = 0;
            if (!c) m_err = 1;
         end
         if (c) begin
            m_matches = 0; m_near = 0; m_best = 0; m_err = 0; m_left = 0; m_pulse = 0;
         end else begin
            m_pulse = (cur == 9 && m_prev != 9) ? 1 : 0;
            if (m_pulse == 1) m_matches++;
            if (m_prev >= NEAR_MIN && m_prev <= 8 && cur < m_prev) m_near++;
            if (cur > m_best) m_best = cur;
            m_left = (m_pulse == 1) ? STRETCH : ((m_left > 0) ? m_left - 1 : 0);
         end
         m_prev = cur;
      end
      x.progress = cur;
      x.pulse    = m_pulse;
      x.mc8      = min_i(m_matches, 255);
      x.nm8      = min_i(m_near, 255);
      x.mc2      = min_i(m_matches, 3);
      x.nm2      = min_i(m_near, 3);
      x.best     = m_best;
      x.led      = (m_left > 0) ? 1 : 0;
      x.err      = m_err;
      exp_q.push_back(x);
   endtask

   task automatic feed(input logic [7:0] e);
      step(1'b0, 1'b0, e);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("progress", int'(bus8.progress), x.progress);
            check("match_pulse", int'(bus8.match_pulse), x.pulse);
            check("match_count", int'(bus8.match_count), x.mc8);
            check("near_miss_count", int'(bus8.near_miss_count), x.nm8);
            check("best_progress", int'(bus8.best_progress), x.best);
            check("led", int'(bus8.led), x.led);
            check("code_err", int'(bus8.code_err), x.err);
            check("match_count_w2", int'(bus2.match_count), x.mc2);
            check("near_miss_count_w2", int'(bus2.near_miss_count), x.nm2);
            check("match_pulse_w2", int'(bus2.match_pulse), x.pulse);
         end
      end
   end

   initial begin : stimulus
      int len;
      int hold;
      bus8.clr = 1'b0;
      bus8.eureka = 8'h00;
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);

      // Full name, then watch the LED stretch out.
      for (int i = 1; i <= 9; i++) feed(codes[i]);
      for (int i = 0; i < 20; i++) feed(8'h00);

      // Seven-letter abort is a near miss; a two-letter abort is not.
      for (int i = 1; i <= 7; i++) feed(codes[i]);
      feed(8'h00);
      feed(8'h80); feed(8'hC0); feed(8'h00);

      // Two matches five cycles apart keep the LED high continuously.
      feed(8'h01);
      for (int i = 0; i < 4; i++) feed(8'h00);
      feed(8'h01);
      for (int i = 0; i < 20; i++) feed(8'h00);

      // Illegal code is sticky until clr.
      feed(8'h55); feed(8'h80); feed(8'hC0);
      step(1'b0, 1'b1, 8'h00);
      feed(8'h00);

      // Five matches saturate the 2-bit counter; clr beats a concurrent match.
      for (int i = 0; i < 5; i++) begin feed(8'h01); feed(8'h00); end
      step(1'b0, 1'b1, 8'h01);
      feed(8'h00);

      // Reset mid-stream with LED lit and six letters of progress.
      feed(8'h01); feed(8'h00);
      for (int i = 1; i <= 6; i++) feed(codes[i]);
      step(1'b1, 1'b0, 8'hFF);
      feed(8'hFF);
      feed(8'h00);

      // Randomised attempts of random length, with stray codes, holds and clears.
      for (int n = 0; n < 80; n++) begin
         len = int'($urandom_range(0, 9));
         for (int i = 1; i <= len; i++) begin
            if ($urandom_range(0, 29) == 0) feed(8'($urandom));
            else step(1'b0, ($urandom_range(0, 39) == 0), codes[i]);
         end
         hold = int'($urandom_range(0, 3));
         for (int i = 0; i < hold; i++) feed(codes[len]);
         feed(codes[$urandom_range(0, len)]);
         if ($urandom_range(0, 49) == 0) step(1'b1, 1'b0, 8'h00);
      end
      for (int i = 0; i < 4; i++) feed(8'h00);

      @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
